// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the parametrised system controller: opcodes,
// controller states and the fixed register addresses used for ALU operands.
package sys_ctrl_pkg;

  localparam logic [7:0] OP_REG_WR  = 8'hAA;
  localparam logic [7:0] OP_REG_RD  = 8'hBB;
  localparam logic [7:0] OP_ALU_OPS = 8'hCC;
  localparam logic [7:0] OP_ALU_NOP = 8'hDD;

  localparam int unsigned REG_A_ADDR = 0;
  localparam int unsigned REG_B_ADDR = 1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_RD_ADDR,
    ST_RD_WAIT,
    ST_ALU_A,
    ST_ALU_B,
    ST_ALU_FUN,
    ST_ALU_WAIT,
    ST_TX_SEND
  } state_e;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int unsigned bits_for(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sys_ctrl_gen_serializer.sv
// Shifts a multi-byte result out LSB first, one byte per cycle, stalling
// whenever the downstream FIFO reports full.
module result_serializer
  import sys_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RES_BYTES  = 2,
  parameter int unsigned CNT_W      = bits_for(RES_BYTES)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            load_i,
  input  logic [RES_BYTES*DATA_WIDTH-1:0] word_i,
  input  logic [CNT_W-1:0]                count_i,
  input  logic                            fifo_full_i,
  output logic [DATA_WIDTH-1:0]           tx_data_o,
  output logic                            tx_vld_o,
  output logic                            busy_o,
  output logic                            done_o
);

  localparam int unsigned WORD_W = RES_BYTES * DATA_WIDTH;

  logic [WORD_W-1:0]     word_q, word_d, cur_word;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cur_cnt;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_vld_q, tx_vld_d;
  logic                  issue;
  wire  [WORD_W-1:0]     shifted;

  // A load is usable in the same cycle, so the first byte leaves one cycle
  // after capture rather than two.
  always_comb begin
    cur_word = load_i ? word_i : word_q;
    cur_cnt  = load_i ? count_i : cnt_q;
  end

  genvar gi;
  generate
    for (gi = 0; gi < RES_BYTES; gi++) begin : g_lane
      if (gi < RES_BYTES - 1) begin : g_mid
        assign shifted[gi*DATA_WIDTH +: DATA_WIDTH] = cur_word[(gi+1)*DATA_WIDTH +: DATA_WIDTH];
      end else begin : g_top
        assign shifted[gi*DATA_WIDTH +: DATA_WIDTH] = '0;
      end
    end
  endgenerate

  always_comb begin
    issue     = (cur_cnt != '0) && !fifo_full_i;
    word_d    = cur_word;
    cnt_d     = cur_cnt;
    tx_data_d = tx_data_q;
    tx_vld_d  = 1'b0;
    if (issue) begin
      tx_data_d = cur_word[DATA_WIDTH-1:0];
      tx_vld_d  = 1'b1;
      word_d    = shifted;
      cnt_d     = cur_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q    <= '0;
      cnt_q     <= '0;
      tx_data_q <= '0;
      tx_vld_q  <= 1'b0;
    end else begin
      word_q    <= word_d;
      cnt_q     <= cnt_d;
      tx_data_q <= tx_data_d;
      tx_vld_q  <= tx_vld_d;
    end
  end

  assign tx_data_o = tx_data_q;
  assign tx_vld_o  = tx_vld_q;
  assign busy_o    = (cnt_q != '0);
  assign done_o    = issue && (cur_cnt == CNT_W'(1));

endmodule

// File: rtl/sys_ctrl_gen.sv
// Command-frame decoder for the REF_CLK domain: turns RX byte frames into
// register-file / ALU accesses and streams results into the TX FIFO.
module sys_ctrl_gen
  import sys_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned FUN_WIDTH      = 4,
  parameter int unsigned RES_BYTES      = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [DATA_WIDTH-1:0]           RX_P_DATA,
  input  logic                            RX_D_VLD,
  input  logic [RES_BYTES*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                            OUT_Valid,
  input  logic [DATA_WIDTH-1:0]           RdData,
  input  logic                            RdData_Valid,
  input  logic                            FIFO_FULL,
  output logic [FUN_WIDTH-1:0]            ALU_FUN,
  output logic                            ALU_EN,
  output logic                            CLK_EN,
  output logic [ADDR_WIDTH-1:0]           Address,
  output logic                            WrEn,
  output logic                            RdEn,
  output logic [DATA_WIDTH-1:0]           WrData,
  output logic [DATA_WIDTH-1:0]           TX_P_DATA,
  output logic                            TX_D_VLD,
  output logic                            clk_div_en,
  output logic                            CMD_ERR,
  output logic                            TIMEOUT
);

  localparam int unsigned RES_W = RES_BYTES * DATA_WIDTH;
  localparam int unsigned CNT_W = bits_for(RES_BYTES);
  localparam int unsigned TMO_W = bits_for(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [DATA_WIDTH-1:0] OP_WR_W  = DATA_WIDTH'(OP_REG_WR);
  localparam logic [DATA_WIDTH-1:0] OP_RD_W  = DATA_WIDTH'(OP_REG_RD);
  localparam logic [DATA_WIDTH-1:0] OP_OPS_W = DATA_WIDTH'(OP_ALU_OPS);
  localparam logic [DATA_WIDTH-1:0] OP_NOP_W = DATA_WIDTH'(OP_ALU_NOP);

  state_e state_q, state_d, op_state;

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wrdata_q, wrdata_d;
  logic [FUN_WIDTH-1:0]  alu_fun_q, alu_fun_d;
  logic                  wren_q, wren_d;
  logic                  rden_q, rden_d;
  logic                  alu_en_q, alu_en_d;
  logic                  alu_en_pend_q, alu_en_pend_d;
  logic                  clk_en_q, clk_en_d;
  logic                  cmd_err_q, cmd_err_d;
  logic                  timeout_q, timeout_d;
  logic                  clk_div_en_q;
  logic [TMO_W-1:0]      tmo_cnt_q, tmo_cnt_d;

  logic                  listening, in_frame, tmo_expire, rx_accept;
  logic                  ser_load, ser_busy, ser_done;
  logic [RES_W-1:0]      ser_word;
  logic [CNT_W-1:0]      ser_count;

  always_comb begin
    op_state = ST_IDLE;
    if (RX_P_DATA == OP_WR_W)       op_state = ST_WR_ADDR;
    else if (RX_P_DATA == OP_RD_W)  op_state = ST_RD_ADDR;
    else if (RX_P_DATA == OP_OPS_W) op_state = ST_ALU_A;
    else if (RX_P_DATA == OP_NOP_W) op_state = ST_ALU_FUN;
  end

  // Bytes are only consumed in states that expect one; elsewhere they vanish.
  always_comb begin
    listening = 1'b0;
    case (state_q)
      ST_IDLE, ST_WR_ADDR, ST_WR_DATA, ST_RD_ADDR,
      ST_ALU_A, ST_ALU_B, ST_ALU_FUN: listening = 1'b1;
      default:                        listening = 1'b0;
    endcase
    in_frame   = (state_q != ST_IDLE) && (state_q != ST_TX_SEND);
    tmo_expire = in_frame && (tmo_cnt_q == TMO_LAST);
    rx_accept  = RX_D_VLD && listening && !tmo_expire;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (tmo_expire) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:     if (rx_accept) state_d = op_state;
        ST_WR_ADDR:  if (rx_accept) state_d = ST_WR_DATA;
        ST_WR_DATA:  if (rx_accept) state_d = ST_IDLE;
        ST_RD_ADDR:  if (rx_accept) state_d = ST_RD_WAIT;
        ST_RD_WAIT:  if (RdData_Valid) state_d = ST_TX_SEND;
        ST_ALU_A:    if (rx_accept) state_d = ST_ALU_B;
        ST_ALU_B:    if (rx_accept) state_d = ST_ALU_FUN;
        ST_ALU_FUN:  if (rx_accept) state_d = ST_ALU_WAIT;
        ST_ALU_WAIT: if (OUT_Valid) state_d = ST_TX_SEND;
        ST_TX_SEND:  if (ser_done || !ser_busy) state_d = ST_IDLE;
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    addr_d        = addr_q;
    wrdata_d      = wrdata_q;
    alu_fun_d     = alu_fun_q;
    clk_en_d      = clk_en_q;
    wren_d        = 1'b0;
    rden_d        = 1'b0;
    cmd_err_d     = 1'b0;
    timeout_d     = 1'b0;
    alu_en_d      = alu_en_pend_q;
    alu_en_pend_d = 1'b0;
    ser_load      = 1'b0;
    ser_word      = '0;
    ser_count     = '0;

    if ((state_d != state_q) || rx_accept) tmo_cnt_d = '0;
    else if (in_frame)                     tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    else                                   tmo_cnt_d = '0;

    if (tmo_expire) begin
      timeout_d = 1'b1;
      clk_en_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (rx_accept && (op_state == ST_IDLE)) cmd_err_d = 1'b1;
        ST_WR_ADDR: if (rx_accept) addr_d = RX_P_DATA[ADDR_WIDTH-1:0];
        ST_WR_DATA: if (rx_accept) begin
          wrdata_d = RX_P_DATA;
          wren_d   = 1'b1;
        end
        ST_RD_ADDR: if (rx_accept) begin
          addr_d = RX_P_DATA[ADDR_WIDTH-1:0];
          rden_d = 1'b1;
        end
        ST_RD_WAIT: if (RdData_Valid) begin
          ser_load  = 1'b1;
          ser_word  = RES_W'(RdData);
          ser_count = CNT_W'(1);
        end
        ST_ALU_A: if (rx_accept) begin
          addr_d   = ADDR_WIDTH'(REG_A_ADDR);
          wrdata_d = RX_P_DATA;
          wren_d   = 1'b1;
        end
        ST_ALU_B: if (rx_accept) begin
          addr_d   = ADDR_WIDTH'(REG_B_ADDR);
          wrdata_d = RX_P_DATA;
          wren_d   = 1'b1;
        end
        // The clock gate opens first; ALU_EN follows a cycle later so the
        // ALU sees a running clock when it starts.
        ST_ALU_FUN: if (rx_accept) begin
          alu_fun_d     = RX_P_DATA[FUN_WIDTH-1:0];
          clk_en_d      = 1'b1;
          alu_en_pend_d = 1'b1;
        end
        ST_ALU_WAIT: if (OUT_Valid) begin
          ser_load  = 1'b1;
          ser_word  = ALU_OUT;
          ser_count = CNT_W'(RES_BYTES);
          clk_en_d  = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      addr_q        <= '0;
      wrdata_q      <= '0;
      alu_fun_q     <= '0;
      wren_q        <= 1'b0;
      rden_q        <= 1'b0;
      alu_en_q      <= 1'b0;
      alu_en_pend_q <= 1'b0;
      clk_en_q      <= 1'b0;
      cmd_err_q     <= 1'b0;
      timeout_q     <= 1'b0;
      clk_div_en_q  <= 1'b0;
      tmo_cnt_q     <= '0;
    end else begin
      addr_q        <= addr_d;
      wrdata_q      <= wrdata_d;
      alu_fun_q     <= alu_fun_d;
      wren_q        <= wren_d;
      rden_q        <= rden_d;
      alu_en_q      <= alu_en_d;
      alu_en_pend_q <= alu_en_pend_d;
      clk_en_q      <= clk_en_d;
      cmd_err_q     <= cmd_err_d;
      timeout_q     <= timeout_d;
      clk_div_en_q  <= 1'b1;
      tmo_cnt_q     <= tmo_cnt_d;
    end
  end

  result_serializer #(
    .DATA_WIDTH (DATA_WIDTH),
    .RES_BYTES  (RES_BYTES),
    .CNT_W      (CNT_W)
  ) u_serializer (
    .clk         (CLK),
    .rst_n       (RST),
    .load_i      (ser_load),
    .word_i      (ser_word),
    .count_i     (ser_count),
    .fifo_full_i (FIFO_FULL),
    .tx_data_o   (TX_P_DATA),
    .tx_vld_o    (TX_D_VLD),
    .busy_o      (ser_busy),
    .done_o      (ser_done)
  );

  assign Address    = addr_q;
  assign WrData     = wrdata_q;
  assign WrEn       = wren_q;
  assign RdEn       = rden_q;
  assign ALU_FUN    = alu_fun_q;
  assign ALU_EN     = alu_en_q;
  assign CLK_EN     = clk_en_q;
  assign CMD_ERR    = cmd_err_q;
  assign TIMEOUT    = timeout_q;
  assign clk_div_en = clk_div_en_q;

endmodule

// File: doc/sys_ctrl_gen.md
# sys_ctrl_gen

Parametrised successor to the system controller. Decodes command frames arriving byte-by-byte from the synchronised UART RX path, drives register-file and ALU accesses, and returns results to the TX FIFO. Adds configurable data/address/result widths, a multi-byte result serialiser with FIFO backpressure, inter-byte frame timeout, and unknown-command reporting. Sits in the REF_CLK domain between the RX data synchroniser, RegFile, ALU/clock gate and the async FIFO write port.

## Interface
- DATA_WIDTH, 8, RX/TX byte and register width
- ADDR_WIDTH, 4, register-file address width
- FUN_WIDTH, 4, ALU function code width
- RES_BYTES, 2, ALU result width in DATA_WIDTH units (1..4)
- TIMEOUT_CYCLES, 4096, max idle cycles inside a frame before abort (≥4)

- CLK  in  1  system clock (REF domain)
- RST  in  1  asynchronous active-low reset
- RX_P_DATA  in  DATA_WIDTH  synchronised received byte
- RX_D_VLD  in  1  one-cycle strobe, RX_P_DATA valid
- ALU_OUT  in  RES_BYTES*DATA_WIDTH  ALU result
- OUT_Valid  in  1  ALU result valid
- RdData  in  DATA_WIDTH  register read data
- RdData_Valid  in  1  read data valid
- FIFO_FULL  in  1  TX FIFO full
- ALU_FUN  out  FUN_WIDTH  registered function code
- ALU_EN  out  1  one-cycle ALU start
- CLK_EN  out  1  ALU clock-gate enable
- Address  out  ADDR_WIDTH  register address
- WrEn, RdEn  out  1  one-cycle register strobes
- WrData  out  DATA_WIDTH  register write data
- TX_P_DATA  out  DATA_WIDTH  byte to FIFO
- TX_D_VLD  out  1  one-cycle FIFO write strobe
- clk_div_en  out  1  constant 1 after reset
- CMD_ERR  out  1  one-cycle pulse, unknown opcode
- TIMEOUT  out  1  one-cycle pulse, frame aborted

## Operation
- All outputs 0 during reset; clk_div_en goes 1 on first CLK edge after reset release.
- Opcodes (first byte in IDLE): 0xAA reg write (ADDR, DATA); 0xBB reg read (ADDR); 0xCC ALU with operands (A, B, FUN); 0xDD ALU no operands (FUN). Address/FUN bytes use low ADDR_WIDTH/FUN_WIDTH bits.
- Other opcode in IDLE: CMD_ERR pulse, stay IDLE, byte dropped.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_A, ALU_B, ALU_FUN, ALU_WAIT, TX_SEND.
- 0xAA: ADDR byte latched into Address; DATA byte → WrData, WrEn pulse, → IDLE.
- 0xBB: ADDR byte → Address, RdEn pulse, → RD_WAIT; RdData_Valid captures RdData as 1-byte result → TX_SEND.
- 0xCC: A byte → write reg 0 (WrEn pulse); B byte → write reg 1; then ALU_FUN.
- 0xDD / ALU_FUN: FUN byte → ALU_FUN latched, CLK_EN=1, ALU_EN pulse next cycle, → ALU_WAIT; OUT_Valid captures ALU_OUT (RES_BYTES) → TX_SEND, CLK_EN=0.
- TX_SEND: emit result bytes LSB first; byte issued only when FIFO_FULL=0 (TX_D_VLD pulse); FIFO_FULL=1 holds current byte; after last byte → IDLE.
- RX bytes arriving in RD_WAIT, ALU_WAIT, TX_SEND are dropped (no CMD_ERR).
- Timeout: counter clears on every state change and every accepted RX_D_VLD; in any non-IDLE state except TX_SEND, reaching TIMEOUT_CYCLES → TIMEOUT pulse, CLK_EN=0, → IDLE. TX_SEND never times out.

## Timing
- Strobes (WrEn, RdEn, ALU_EN, TX_D_VLD, CMD_ERR, TIMEOUT) registered, asserted cycle after triggering event, exactly one cycle wide.
- Reg write: WrEn one cycle after DATA strobe.
- ALU: ALU_EN two cycles after FUN strobe; CLK_EN high from one cycle after FUN strobe until cycle after OUT_Valid.
- First TX_D_VLD one cycle after result capture if FIFO not full; consecutive bytes back-to-back when FIFO_FULL stays 0.
- RX_D_VLD same cycle as timeout expiry: timeout wins, byte dropped.

## Structure
- Package sys_ctrl_pkg: opcode constants (0xAA, 0xBB, 0xCC, 0xDD), state enumeration, operand register addresses (0, 1).
- Sub-module result_serializer: loads RES_BYTES×DATA_WIDTH word plus byte count, shifts out bytes under FIFO_FULL, signals done.

## Test plan
- 0xAA,0x05,0x3C → WrEn one cycle, Address=5, WrData=0x3C; no TX.
- 0xBB,0x05; RdData=0x3C with RdData_Valid → single TX_D_VLD, TX_P_DATA=0x3C.
- 0xCC,0x10,0x20,0x00 with ALU_OUT=0x0030 → writes reg0=0x10, reg1=0x20, ALU_EN pulse, TX bytes 0x30 then 0x00.
- Same as above with FIFO_FULL=1 for 20 cycles at first byte → no TX_D_VLD while full, then 0x30,0x00 in order, no loss.
- 0xAA,0x05 then silence TIMEOUT_CYCLES → TIMEOUT pulse, no WrEn; next 0xBB decodes normally.
- 0x7E in IDLE → CMD_ERR pulse, state IDLE; RST low mid-ALU_WAIT → all outputs 0, CLK_EN=0.
